// File: rtl/wb_dbg_master.sv
// UART-byte-driven Wishbone classic master: 01/02 opcode, 4 address bytes, 4 write-data bytes.
// Optional bus timeout via `WB_DBG_TIMEOUT_EN (NAK 0x15 after timeout_cycles without ack/err).
module wb_dbg_master #(
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_avail,
  output logic        rx_ack,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] WDATA = 3'd2;
  localparam logic [2:0] BUS   = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  logic [2:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        cyc_q, cyc_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] rsp_q, rsp_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_wr_q, tx_wr_d;
  logic        rx_ack_q, rx_ack_d;
  logic        hold_q, hold_d;
  logic [7:0]  byte_q, byte_d;
  logic        accept, take, term, tmo_hit;

`ifdef WB_DBG_TIMEOUT_EN
  localparam int TW = $clog2(timeout_cycles + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  assign tmo_hit = (tmo_q == TW'(timeout_cycles - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    cyc_d     = cyc_q;
    sel_d     = sel_q;
    rsp_d     = rsp_q;
    tx_data_d = tx_data_q;
    tx_wr_d   = 1'b0;
    term      = 1'b0;

    // One byte per rx_avail assertion: hold_q blocks re-taking a byte the UART keeps presenting.
    accept   = (state_q == IDLE) || (state_q == ADDR) || (state_q == WDATA);
    take     = accept && rx_avail && !rx_ack_q && !hold_q;
    rx_ack_d = take;
    hold_d   = rx_avail && (hold_q || take);
    byte_d   = take ? rx_data : byte_q;

    // The byte captured on the take cycle is acted on during the rx_ack pulse.
    case (state_q)
      IDLE: if (rx_ack_q) begin
        cnt_d = 2'd0;
        if (byte_q == 8'h01) begin
          we_d    = 1'b1;
          state_d = ADDR;
        end else if (byte_q == 8'h02) begin
          we_d    = 1'b0;
          state_d = ADDR;
        end
      end
      ADDR: if (rx_ack_q) begin
        adr_d = {adr_q[23:0], byte_q};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          if (we_q) state_d = WDATA;
          else begin
            state_d = BUS;
            cyc_d   = 1'b1;
            sel_d   = 4'hF;
          end
        end
      end
      WDATA: if (rx_ack_q) begin
        dat_d = {dat_q[23:0], byte_q};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          sel_d   = 4'hF;
        end
      end
      BUS: begin
        if (wb_err_i) begin
          term   = 1'b1;
          rsp_d  = {RSP_NAK, 24'h0};
          last_d = 2'd0;
        end else if (wb_ack_i) begin
          term = 1'b1;
          if (we_q) begin
            rsp_d  = {RSP_ACK, 24'h0};
            last_d = 2'd0;
          end else begin
            rsp_d  = wb_dat_i;
            last_d = 2'd3;
          end
        end else if (tmo_hit) begin
          term   = 1'b1;
          rsp_d  = {RSP_NAK, 24'h0};
          last_d = 2'd0;
        end
        if (term) begin
          cyc_d   = 1'b0;
          sel_d   = 4'h0;
          cnt_d   = 2'd0;
          state_d = RESP;
        end
      end
      RESP: if (!tx_busy && !tx_wr_q) begin
        tx_wr_d   = 1'b1;
        tx_data_d = rsp_q[31:24];
        rsp_d     = {rsp_q[23:0], 8'h00};
        cnt_d     = cnt_q + 2'd1;
        if (cnt_q == last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef WB_DBG_TIMEOUT_EN
    tmo_d = (state_q == BUS && !term) ? tmo_q + 1'b1 : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      cnt_q     <= 2'd0;
      last_q    <= 2'd0;
      adr_q     <= 32'h0;
      dat_q     <= 32'h0;
      cyc_q     <= 1'b0;
      sel_q     <= 4'h0;
      rsp_q     <= 32'h0;
      tx_data_q <= 8'h0;
      tx_wr_q   <= 1'b0;
      rx_ack_q  <= 1'b0;
      hold_q    <= 1'b0;
      byte_q    <= 8'h0;
`ifdef WB_DBG_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      cyc_q     <= cyc_d;
      sel_q     <= sel_d;
      rsp_q     <= rsp_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      rx_ack_q  <= rx_ack_d;
      hold_q    <= hold_d;
      byte_q    <= byte_d;
`ifdef WB_DBG_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign rx_ack   = rx_ack_q;
  assign tx_data  = tx_data_q;
  assign tx_wr    = tx_wr_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;

endmodule
